// File: rtl/param_stack_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : param_stack_cpu_pkg
//  Purpose  : Shared constants for the parametrised stack calculator:
//             opcode codes, PUSF/REPL/BINA sub-op selectors, stack command
//             encoding, FSM state encoding and status-word bit positions.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package param_stack_cpu_pkg;

   // Opcodes
   localparam logic [3:0] OP_NOOP = 4'h0;
   localparam logic [3:0] OP_PUSH = 4'h1;
   localparam logic [3:0] OP_POP  = 4'h2;
   localparam logic [3:0] OP_OUTL = 4'h3;
   localparam logic [3:0] OP_OUTH = 4'h4;
   localparam logic [3:0] OP_SWAP = 4'h5;
   localparam logic [3:0] OP_PUSF = 4'h6;
   localparam logic [3:0] OP_REPL = 4'h7;
   localparam logic [3:0] OP_BINA = 4'h8;
   localparam logic [3:0] OP_MULT = 4'h9;
   localparam logic [3:0] OP_IDIV = 4'hA;
   localparam logic [3:0] OP_CLFL = 4'hB;
   localparam logic [3:0] OP_CLRS = 4'hC;
   localparam logic [3:0] OP_PDEP = 4'hD;

   // PUSF selectors
   localparam logic [3:0] PUSF_DUP    = 4'd0;
   localparam logic [3:0] PUSF_SECOND = 4'd1;
   localparam logic [3:0] PUSF_STATUS = 4'd2;

   // REPL selectors
   localparam logic [3:0] REPL_NOT = 4'd0;
   localparam logic [3:0] REPL_NEG = 4'd1;
   localparam logic [3:0] REPL_INC = 4'd2;
   localparam logic [3:0] REPL_DEC = 4'd3;
   localparam logic [3:0] REPL_SHR = 4'd4;
   localparam logic [3:0] REPL_SHL = 4'd5;
   localparam logic [3:0] REPL_ROR = 4'd6;
   localparam logic [3:0] REPL_ROL = 4'd7;
   localparam logic [3:0] REPL_REV = 4'd8;

   // BINA selectors
   localparam logic [3:0] BINA_ADD   = 4'd0;
   localparam logic [3:0] BINA_AND   = 4'd1;
   localparam logic [3:0] BINA_OR    = 4'd2;
   localparam logic [3:0] BINA_XOR   = 4'd3;
   localparam logic [3:0] BINA_ADDC  = 4'd4;
   localparam logic [3:0] BINA_MULLO = 4'd5;
   localparam logic [3:0] BINA_MULHI = 4'd6;
   localparam logic [3:0] BINA_DIV   = 4'd9;
   localparam logic [3:0] BINA_MOD   = 4'd10;

   // Stack commands. REPLACE2 drops the top two entries and pushes one word.
   typedef enum logic [2:0] {
      SCMD_IDLE     = 3'd0,
      SCMD_PUSH     = 3'd1,
      SCMD_POP      = 3'd2,
      SCMD_SWAP     = 3'd3,
      SCMD_REPLACE1 = 3'd4,
      SCMD_REPLACE2 = 3'd5,
      SCMD_CLEAR    = 3'd6
   } stack_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_EXEC2 = 2'd2
   } cpu_state_t;

   // Status word bit positions {udf, ovf, error, carry}
   localparam int STAT_CARRY = 0;
   localparam int STAT_ERROR = 1;
   localparam int STAT_OVF   = 2;
   localparam int STAT_UDF   = 3;

endpackage
`default_nettype wire

// File: rtl/param_stack_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : param_stack_regfile
//  Purpose  : DEPTH-entry, WIDTH-bit stack storage with an entry counter.
//             Executes one stack command per cycle; illegal commands
//             (push when full, pop when empty, ...) are ignored.
//  Ports    : clk, rst_n         clock / async active-low reset (clears count)
//             cmd, data          stack command and write word
//             top, second        top entry / entry below (0 if absent)
//             depth              current entry count
//             full, empty        capacity status
//  Revision : 1.0 - initial release
// ============================================================================
module param_stack_regfile
   import param_stack_cpu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  stack_cmd_t                 cmd,
   input  logic [WIDTH-1:0]           data,
   output logic [WIDTH-1:0]           top,
   output logic [WIDTH-1:0]           second,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       full,
   output logic                       empty
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    count;
   logic [IW-1:0]    top_idx;
   logic [IW-1:0]    sec_idx;
   logic [IW-1:0]    wr_idx;
   logic             has_two;

   assign top_idx = IW'(count - CW'(1));
   assign sec_idx = IW'(count - CW'(2));
   assign wr_idx  = IW'(count);
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign has_two = (count >= CW'(2));
   assign depth   = count;
   assign top     = empty   ? '0 : mem[top_idx];
   assign second  = has_two ? mem[sec_idx] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         case (cmd)
            SCMD_PUSH:     if (!full)   count <= count + CW'(1);
            SCMD_POP:      if (!empty)  count <= count - CW'(1);
            SCMD_REPLACE2: if (has_two) count <= count - CW'(1);
            SCMD_CLEAR:    count <= '0;
            default:       ;
         endcase
      end
   end

   // Storage contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      case (cmd)
         SCMD_PUSH:     if (!full)   mem[wr_idx]  <= data;
         SCMD_REPLACE1: if (!empty)  mem[top_idx] <= data;
         SCMD_REPLACE2: if (has_two) mem[sec_idx] <= data;
         SCMD_SWAP: begin
            if (has_two) begin
               mem[top_idx] <= mem[sec_idx];
               mem[sec_idx] <= mem[top_idx];
            end
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/param_stack_cpu.sv
`default_nettype none
// ============================================================================
//  Module   : param_stack_cpu
//  Purpose  : Parametrised stack calculator. Accepts one opcode per
//             valid/ready handshake and executes it on a hardware stack,
//             with sticky carry/error/overflow/underflow flags and a
//             2*WIDTH output latch.
//  Ports    : clk, rst_n              clock / async active-low reset
//             op_valid, op_ready     opcode handshake
//             opcode, operand        operation and immediate / sub-op
//             out_word               output latch (OUTL/OUTH)
//             top_word, second_word  top two stack entries
//             depth                  current entry count
//             carry_flag, error_flag, ovf_flag, udf_flag  status flags
//  Revision : 1.0 - initial release
// ============================================================================
module param_stack_cpu
   import param_stack_cpu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       op_valid,
   output logic                       op_ready,
   input  logic [3:0]                 opcode,
   input  logic [WIDTH-1:0]           operand,
   output logic [2*WIDTH-1:0]         out_word,
   output logic [WIDTH-1:0]           top_word,
   output logic [WIDTH-1:0]           second_word,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       carry_flag,
   output logic                       error_flag,
   output logic                       ovf_flag,
   output logic                       udf_flag
);

   localparam int CW = $clog2(DEPTH+1);

   cpu_state_t         state, state_nx;
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   arg_q;
   logic [WIDTH-1:0]   hi_q, hi_nx;
   logic               pend2, pend2_nx;
   logic [2*WIDTH-1:0] out_nx;
   logic               carry_nx, error_nx, ovf_nx, udf_nx;

   stack_cmd_t         cmd;
   logic [WIDTH-1:0]   wdata;
   logic               full, empty;

   logic [3:0]         sel;
   logic [WIDTH-1:0]   a, b;
   logic [3:0]         status;
   logic [CW-1:0]      need;
   logic               grow;
   logic               lacking;

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     sum_ab, sum_abc;
   logic [WIDTH-1:0]   a_safe, quot, rem, rev, repl_res, bina_res;

   param_stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
      .clk    (clk),
      .rst_n  (rst_n),
      .cmd    (cmd),
      .data   (wdata),
      .top    (top_word),
      .second (second_word),
      .depth  (depth),
      .full   (full),
      .empty  (empty)
   );

   assign op_ready = (state == ST_IDLE);
   assign sel      = arg_q[3:0];
   assign a        = top_word;
   assign b        = second_word;

   always_comb begin
      status             = '0;
      status[STAT_CARRY] = carry_flag;
      status[STAT_ERROR] = error_flag;
      status[STAT_OVF]   = ovf_flag;
      status[STAT_UDF]   = udf_flag;
   end

   // ---------------- ALU datapath ----------------
   assign prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign sum_ab  = {1'b0, a} + {1'b0, b};
   assign sum_abc = sum_ab + {{WIDTH{1'b0}}, carry_flag};
   // Divisor forced non-zero so the divider never sees 0; the a==0 case
   // is overridden to a zero result below.
   assign a_safe  = (a == '0) ? WIDTH'(1) : a;
   assign quot    = (a == '0) ? '0 : b / a_safe;
   assign rem     = (a == '0) ? '0 : b % a_safe;

   for (genvar i = 0; i < WIDTH; i++) begin : g_rev
      assign rev[i] = a[WIDTH-1-i];
   end

   always_comb begin
      repl_res = '0;
      case (sel)
         REPL_NOT: repl_res = ~a;
         REPL_NEG: repl_res = -a;
         REPL_INC: repl_res = a + WIDTH'(1);
         REPL_DEC: repl_res = a - WIDTH'(1);
         REPL_SHR: repl_res = a >> 1;
         REPL_SHL: repl_res = a << 1;
         REPL_ROR: repl_res = {a[0], a[WIDTH-1:1]};
         REPL_ROL: repl_res = {a[WIDTH-2:0], a[WIDTH-1]};
         REPL_REV: repl_res = rev;
         default:  repl_res = '0;
      endcase
   end

   always_comb begin
      bina_res = '0;
      case (sel)
         BINA_ADD:   bina_res = sum_ab[WIDTH-1:0];
         BINA_AND:   bina_res = a & b;
         BINA_OR:    bina_res = a | b;
         BINA_XOR:   bina_res = a ^ b;
         BINA_ADDC:  bina_res = sum_abc[WIDTH-1:0];
         BINA_MULLO: bina_res = prod[WIDTH-1:0];
         BINA_MULHI: bina_res = prod[2*WIDTH-1:WIDTH];
         BINA_DIV:   bina_res = quot;
         BINA_MOD:   bina_res = rem;
         default:    bina_res = '0;
      endcase
   end

   // Operand requirement and whether the op grows the stack by one.
   always_comb begin
      need = '0;
      grow = 1'b0;
      case (op_q)
         OP_PUSH, OP_PDEP: grow = 1'b1;
         OP_POP, OP_OUTL, OP_OUTH, OP_REPL: need = CW'(1);
         OP_SWAP, OP_BINA, OP_MULT, OP_IDIV: need = CW'(2);
         OP_PUSF: begin
            case (sel)
               PUSF_DUP:    begin need = CW'(1); grow = 1'b1; end
               PUSF_SECOND: begin need = CW'(2); grow = 1'b1; end
               PUSF_STATUS: grow = 1'b1;
               default:     ;
            endcase
         end
         default: ;
      endcase
      lacking = (need == CW'(1)) ? empty : (depth < need);
   end

   // ---------------- FSM next state / actions ----------------
   always_comb begin
      state_nx = state;
      cmd      = SCMD_IDLE;
      wdata    = '0;
      hi_nx    = hi_q;
      pend2_nx = pend2;
      out_nx   = out_word;
      carry_nx = carry_flag;
      error_nx = error_flag;
      ovf_nx   = ovf_flag;
      udf_nx   = udf_flag;

      case (state)
         ST_IDLE: begin
            if (op_valid) state_nx = ST_EXEC;
         end

         ST_EXEC: begin
            // Two-cycle ops always take EXEC2 so handshake timing is fixed,
            // even when the op itself was rejected.
            state_nx = (op_q == OP_MULT || op_q == OP_IDIV) ? ST_EXEC2 : ST_IDLE;
            pend2_nx = 1'b0;
            if (lacking) begin
               udf_nx = 1'b1;
            end else if (grow && full) begin
               ovf_nx = 1'b1;
            end else begin
               case (op_q)
                  OP_PUSH: begin cmd = SCMD_PUSH; wdata = arg_q; end
                  OP_POP:  cmd = SCMD_POP;
                  OP_OUTL: out_nx[WIDTH-1:0] = a;
                  OP_OUTH: out_nx[2*WIDTH-1:WIDTH] = a;
                  OP_SWAP: cmd = SCMD_SWAP;
                  OP_PUSF: begin
                     case (sel)
                        PUSF_DUP:    begin cmd = SCMD_PUSH; wdata = a; end
                        PUSF_SECOND: begin cmd = SCMD_PUSH; wdata = b; end
                        PUSF_STATUS: begin cmd = SCMD_PUSH; wdata = WIDTH'(status); end
                        default:     ;
                     endcase
                  end
                  OP_REPL: begin cmd = SCMD_REPLACE1; wdata = repl_res; end
                  OP_BINA: begin
                     cmd   = SCMD_REPLACE2;
                     wdata = bina_res;
                     if (sel == BINA_ADD)  carry_nx = sum_ab[WIDTH];
                     if (sel == BINA_ADDC) carry_nx = sum_abc[WIDTH];
                     if ((sel == BINA_DIV || sel == BINA_MOD) && a == '0) error_nx = 1'b1;
                  end
                  OP_MULT: begin
                     cmd      = SCMD_REPLACE2;
                     wdata    = prod[WIDTH-1:0];
                     hi_nx    = prod[2*WIDTH-1:WIDTH];
                     pend2_nx = 1'b1;
                  end
                  OP_IDIV: begin
                     cmd      = SCMD_REPLACE2;
                     wdata    = quot;
                     hi_nx    = rem;
                     pend2_nx = 1'b1;
                     if (a == '0) error_nx = 1'b1;
                  end
                  OP_CLFL: begin
                     carry_nx = 1'b0;
                     error_nx = 1'b0;
                     ovf_nx   = 1'b0;
                     udf_nx   = 1'b0;
                  end
                  OP_CLRS: cmd = SCMD_CLEAR;
                  OP_PDEP: begin cmd = SCMD_PUSH; wdata = WIDTH'(depth); end
                  default: ;
               endcase
            end
         end

         ST_EXEC2: begin
            state_nx = ST_IDLE;
            pend2_nx = 1'b0;
            if (pend2) begin
               cmd   = SCMD_PUSH;
               wdata = hi_q;
            end
         end

         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= OP_NOOP;
         arg_q      <= '0;
         hi_q       <= '0;
         pend2      <= 1'b0;
         out_word   <= '0;
         carry_flag <= 1'b0;
         error_flag <= 1'b0;
         ovf_flag   <= 1'b0;
         udf_flag   <= 1'b0;
      end else begin
         if (state == ST_IDLE && op_valid) begin
            op_q  <= opcode;
            arg_q <= operand;
         end
         hi_q       <= hi_nx;
         pend2      <= pend2_nx;
         out_word   <= out_nx;
         carry_flag <= carry_nx;
         error_flag <= error_nx;
         ovf_flag   <= ovf_nx;
         udf_flag   <= udf_nx;
      end
   end

endmodule
`default_nettype wire
